aes_round_sequencer: RTL

- Iterative AES controller that drives one shared single-round unit through a whole block operation.
- Accepts a 128-bit block plus an encrypt/decrypt flag over a valid/ready handshake.
- Fetches round keys from an external expanded-key RAM, does the initial whitening XOR itself, loads each key into the round unit, and issues NUM_ROUNDS round operations.
- Returns the finished block over a valid/ready response port, with a watchdog error flag.

---
 rtl/aes_round_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES block controller driving a shared single-round unit; rsp_valid rises 3+4*NUM_ROUNDS cycles after accept,
// plus any extra round-unit latency. One block in flight; the response is held until rsp_ready, and no request is accepted meanwhile.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_ADDR_W = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [127:0]          req_data,
  input  logic                  req_en_de,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [127:0]          rsp_data,
  output logic                  rsp_en_de,
  output logic                  rsp_err,
  output logic [KEY_ADDR_W-1:0] rk_addr,
  input  logic [127:0]          rk_data,
  output logic [127:0]          rnd_key,
  output logic                  rnd_set_key,
  output logic                  rnd_set_inv_key,
  output logic                  rnd_valid,
  output logic [127:0]          rnd_data,
  output logic                  rnd_en_de,
  output logic                  rnd_final,
  input  logic                  rnd_out_valid,
  input  logic [127:0]          rnd_out_data,
  output logic                  busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [KEY_ADDR_W-1:0] LAST_R = KEY_ADDR_W'(NUM_ROUNDS);
  localparam logic [WD_W-1:0]       WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WH_FETCH,
    S_WH_APPLY,
    S_KEY_FETCH,
    S_KEY_SET,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [127:0]          blk_q, blk_d;
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic [KEY_ADDR_W-1:0] r_q, r_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic [KEY_ADDR_W-1:0] key_addr;
  logic [WD_W-1:0]       wd_inc;

  // Decrypt walks the expanded key schedule backwards from the last round key.
  assign key_addr = mode_q ? (LAST_R - r_q) : r_q;
  assign wd_inc   = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      r_q     <= r_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    blk_d           = blk_q;
    mode_d          = mode_q;
    err_d           = err_q;
    r_d             = r_q;
    wd_d            = wd_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = '0;
    rsp_en_de       = 1'b0;
    rsp_err         = 1'b0;
    rk_addr         = '0;
    rnd_key         = '0;
    rnd_set_key     = 1'b0;
    rnd_set_inv_key = 1'b0;
    rnd_valid       = 1'b0;
    rnd_data        = '0;
    rnd_en_de       = 1'b0;
    rnd_final       = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          blk_d   = req_data;
          mode_d  = req_en_de;
          err_d   = 1'b0;
          r_d     = '0;
          state_d = S_WH_FETCH;
        end
      end
      S_WH_FETCH: begin
        rk_addr = key_addr;
        state_d = S_WH_APPLY;
      end
      S_WH_APPLY: begin
        blk_d   = blk_q ^ rk_data;
        r_d     = KEY_ADDR_W'(1);
        state_d = S_KEY_FETCH;
      end
      S_KEY_FETCH: begin
        rk_addr = key_addr;
        state_d = S_KEY_SET;
      end
      S_KEY_SET: begin
        rnd_key         = rk_data;
        rnd_set_key     = ~mode_q;
        rnd_set_inv_key = mode_q;
        state_d         = S_ISSUE;
      end
      S_ISSUE: begin
        rnd_valid = 1'b1;
        rnd_data  = blk_q;
        rnd_en_de = mode_q;
        rnd_final = (r_q == LAST_R);
        wd_d      = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (rnd_out_valid) begin
          blk_d = rnd_out_data;
          if (r_q == LAST_R) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            r_d     = r_q + KEY_ADDR_W'(1);
            state_d = S_KEY_FETCH;
          end
        end else begin
          wd_d = wd_inc;
          // A round unit that never answers must not hang the port; report it as an empty block.
          if (wd_inc == WD_MAX) begin
            blk_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = blk_q;
        rsp_en_de = mode_q;
        rsp_err   = err_q;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
